motor_pwm_core: RTL and testbench

User-logic stage inside the motor AXI4-Lite peripheral. It sits directly downstream of the four-register slave interface: the control, period and duty registers written over S00_AXI are consumed here and turned into a glitch-free H-bridge PWM drive. Parameter changes apply only at period boundaries, and direction reversals are protected by a dead-time interval. A status word is returned for the slave's read-back register.

---
 rtl/motor_pkg.sv | 22 ++
 rtl/motor_pwm_counter.sv | 54 +++++
 rtl/motor_pwm_core.sv | 213 +++++++++++++++++++++
 tb/tb_motor_pwm_core.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM user-logic stage: FSM state encoding,
// control register bit indices and status word layout.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } motor_state_t;

    // Control register bit indices
    localparam int CTRL_EN  = 0;
    localparam int CTRL_DIR = 1;

    // Status word layout
    localparam int STAT_RUN      = 0;
    localparam int STAT_DEAD     = 1;
    localparam int STAT_DIR      = 2;
    localparam int STAT_DUTY_LSB = 16;
    localparam int STAT_DUTY_W   = 16;

endpackage

// File: rtl/motor_pwm_counter.sv
// Period counter for the motor PWM core. Counts 0..period-1 and wraps,
// exposes the combinational next count so the core can register its outputs
// from next-state values, and produces a registered period_tick that is high
// on the last cycle of each running period.
module motor_pwm_counter
    import motor_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 hold,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic                 run_next,
    input  logic [CNT_WIDTH-1:0] period_next,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [CNT_WIDTH-1:0] cnt_next,
    output logic                 wrap,
    output logic                 tick
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic tick_next;

    // Next count: clear wins over hold, otherwise count up and wrap at period-1
    always_comb begin
        wrap      = (cnt == (period - ONE));
        cnt_next  = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (hold) begin
            cnt_next = cnt;
        end else if (wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + ONE;
        end
        tick_next = run_next && (cnt_next == (period_next - ONE));
    end

    // Count and tick registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= tick_next;
        end
    end

endmodule

// File: rtl/motor_pwm_core.sv
// Motor PWM core: turns the control/period/duty registers of the AXI4-Lite
// slave into a glitch-free H-bridge drive. Period, duty and direction are
// shadowed and only take effect at a period wrap; a direction change inserts
// DEADTIME cycles with both legs low. All outputs are registered and derived
// from next-state values so no input reaches an output combinationally.
// Optional feature: define MOTOR_SOFT_START_EN to ramp the active duty from 0
// by RAMP_STEP per period whenever RUN is entered.
module motor_pwm_core
    import motor_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int DEADTIME  = 32,
    parameter int RAMP_STEP = 1
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] ctrl_reg,
    input  logic [31:0] period_reg,
    input  logic [31:0] duty_reg,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic        period_tick,
    output logic [31:0] status
);

`ifdef MOTOR_SOFT_START_EN
    localparam bit SOFT_START = 1'b1;
`else
    localparam bit SOFT_START = 1'b0;
`endif

    localparam int                   DW        = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0]        DEAD_LOAD = DW'(DEADTIME - 1);
    localparam logic [CNT_WIDTH:0]   RAMP_INC  = (CNT_WIDTH + 1)'(RAMP_STEP);

    // Register fields
    logic                 en;
    logic                 reg_dir;
    logic [CNT_WIDTH-1:0] reg_period;
    logic [CNT_WIDTH-1:0] reg_duty;
    logic                 unused_bits;

    // FSM state and shadows
    motor_state_t         state, state_n;
    logic [CNT_WIDTH-1:0] period_sh, period_n;
    logic [CNT_WIDTH-1:0] duty_sh, duty_n;
    logic [CNT_WIDTH-1:0] duty_act, act_n;
    logic                 dir_pend, pend_n;
    logic                 dir_app, dir_n;
    logic [DW-1:0]        dead_cnt, dead_n;

    // Counter interface
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 wrap;
    logic                 clear;
    logic                 hold;

    // Registered output next values
    logic                 pwm_a_n;
    logic                 pwm_b_n;
    logic [31:0]          status_n;

    assign en          = ctrl_reg[CTRL_EN];
    assign reg_dir     = ctrl_reg[CTRL_DIR];
    assign reg_period  = period_reg[CNT_WIDTH-1:0];
    assign reg_duty    = duty_reg[CNT_WIDTH-1:0];
    assign unused_bits = ^{ctrl_reg, period_reg, duty_reg};

    // Soft-start ramp: step up towards the target, computed one bit wider so
    // the sum cannot wrap; a lower target is taken immediately.
    function automatic logic [CNT_WIDTH-1:0] ramp_duty(
        input logic [CNT_WIDTH-1:0] act,
        input logic [CNT_WIDTH-1:0] target
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, act} + RAMP_INC;
        if (sum > {1'b0, target}) begin
            return target;
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    // Active duty on entry to RUN (from IDLE or DEAD)
    function automatic logic [CNT_WIDTH-1:0] start_duty(input logic [CNT_WIDTH-1:0] d);
        return SOFT_START ? '0 : d;
    endfunction

    // Active duty after a wrap that stays in RUN
    function automatic logic [CNT_WIDTH-1:0] wrap_duty(
        input logic [CNT_WIDTH-1:0] act,
        input logic [CNT_WIDTH-1:0] d
    );
        return SOFT_START ? ramp_duty(act, d) : d;
    endfunction

    // Next-state logic for FSM, shadows, dead-time counter and active duty
    always_comb begin
        state_n  = state;
        period_n = period_sh;
        duty_n   = duty_sh;
        act_n    = duty_act;
        pend_n   = dir_pend;
        dir_n    = dir_app;
        dead_n   = dead_cnt;
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_period != '0) begin
                        state_n  = RUN;
                        period_n = reg_period;
                        duty_n   = reg_duty;
                        pend_n   = reg_dir;
                        dir_n    = reg_dir;
                        act_n    = start_duty(reg_duty);
                    end
                end
                RUN: begin
                    if (wrap) begin
                        period_n = reg_period;
                        duty_n   = reg_duty;
                        pend_n   = reg_dir;
                        if (reg_period == '0) begin
                            state_n = IDLE;
                        end else if (reg_dir != dir_app) begin
                            state_n = DEAD;
                            dead_n  = DEAD_LOAD;
                        end else begin
                            act_n = wrap_duty(duty_act, reg_duty);
                        end
                    end
                end
                DEAD: begin
                    if (dead_cnt == '0) begin
                        state_n = RUN;
                        dir_n   = dir_pend;
                        act_n   = start_duty(duty_sh);
                    end else begin
                        dead_n = dead_cnt - DW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Counter control: restart on every state change or in IDLE, freeze in DEAD
    always_comb begin
        clear = (state_n == IDLE) || (state_n != state);
        hold  = (state == DEAD);
    end

    motor_pwm_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .clear       (clear),
        .hold        (hold),
        .period      (period_sh),
        .run_next    (state_n == RUN),
        .period_next (period_n),
        .cnt         (cnt),
        .cnt_next    (cnt_next),
        .wrap        (wrap),
        .tick        (period_tick)
    );

    // Output next values: only the applied-direction leg can be high, and only in RUN
    always_comb begin
        pwm_a_n  = (state_n == RUN) && !dir_n && (cnt_next < act_n);
        pwm_b_n  = (state_n == RUN) &&  dir_n && (cnt_next < act_n);
        status_n = '0;
        if (state_n != IDLE) begin
            status_n[STAT_RUN]                          = (state_n == RUN);
            status_n[STAT_DEAD]                         = (state_n == DEAD);
            status_n[STAT_DIR]                          = dir_n;
            status_n[STAT_DUTY_LSB +: STAT_DUTY_W]      = STAT_DUTY_W'(act_n);
        end
    end

    // State, shadow and output registers
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= IDLE;
            period_sh <= '0;
            duty_sh   <= '0;
            duty_act  <= '0;
            dir_pend  <= 1'b0;
            dir_app   <= 1'b0;
            dead_cnt  <= '0;
            pwm_a     <= 1'b0;
            pwm_b     <= 1'b0;
            status    <= '0;
        end else begin
            state     <= state_n;
            period_sh <= period_n;
            duty_sh   <= duty_n;
            duty_act  <= act_n;
            dir_pend  <= pend_n;
            dir_app   <= dir_n;
            dead_cnt  <= dead_n;
            pwm_a     <= pwm_a_n;
            pwm_b     <= pwm_b_n;
            status    <= status_n;
        end
    end

endmodule

// File: tb/tb_motor_pwm_core.sv
// Directed bench for motor_pwm_core: reset, steady PWM, duty extremes,
// direction reversal with dead time, enable drop, reset during dead time,
// period zero, and (with MOTOR_SOFT_START_EN) the soft-start ramp.
module tb_motor_pwm_core;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] ctrl_reg;
    logic [31:0] period_reg;
    logic [31:0] duty_reg;
    logic        pwm_a;
    logic        pwm_b;
    logic        period_tick;
    logic [31:0] status;

    int total = 0;
    int bad   = 0;

    motor_pwm_core #(
        .CNT_WIDTH (16),
        .DEADTIME  (32),
        .RAMP_STEP (1)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .ctrl_reg    (ctrl_reg),
        .period_reg  (period_reg),
        .duty_reg    (duty_reg),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .period_tick (period_tick),
        .status      (status)
    );

    always #5 ACLK = ~ACLK;

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check RUN cycles with counter positions from..to of a period
    task automatic chk_run(input logic dir, input int hi, input int per,
                           input logic [31:0] st, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            cyc();
            chk("pwm_a", 32'(pwm_a), 32'(!dir && (i < hi)));
            chk("pwm_b", 32'(pwm_b), 32'(dir && (i < hi)));
            chk("tick", 32'(period_tick), 32'(i == per - 1));
            chk("status", status, st);
        end
    endtask

    // Check cycles where both legs are low and the block is idle
    task automatic chk_idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("idle_pwm_a", 32'(pwm_a), 32'd0);
            chk("idle_pwm_b", 32'(pwm_b), 32'd0);
            chk("idle_tick", 32'(period_tick), 32'd0);
            chk("idle_status", status, 32'd0);
        end
    endtask

    // Check dead-time cycles: both legs low, in_deadtime set, not running
    task automatic chk_dead(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("dead_pwm_a", 32'(pwm_a), 32'd0);
            chk("dead_pwm_b", 32'(pwm_b), 32'd0);
            chk("dead_tick", 32'(period_tick), 32'd0);
            chk("dead_bits", {30'd0, status[1:0]}, 32'd2);
        end
    endtask

    initial begin
        // Reset with registers already programmed
        ARESETN    = 1'b0;
        ctrl_reg   = 32'd0;
        period_reg = 32'd10;
        duty_reg   = 32'd3;
        chk_idle(2);
        ctrl_reg = 32'd1;
        chk_idle(1);
        ARESETN = 1'b1;

`ifdef MOTOR_SOFT_START_EN
        // Soft start: duty 5 ramps 0,1,2,3,4,5,5
        duty_reg = 32'd5;
        for (int k = 0; k < 7; k++) begin
            int h;
            h = (k < 5) ? k : 5;
            chk_run(1'b0, h, 10, {16'(h), 16'h0001}, 0, 9);
        end
`else
        // Forward, period 10, duty 3: first RUN cycle right after enable
        chk_run(1'b0, 3, 10, 32'h0003_0001, 0, 9);
        chk_run(1'b0, 3, 10, 32'h0003_0001, 0, 9);

        // Duty 0: constant low
        duty_reg = 32'd0;
        chk_run(1'b0, 0, 10, 32'h0000_0001, 0, 9);

        // Duty above period: constant high
        duty_reg = 32'd12;
        chk_run(1'b0, 10, 10, 32'h000C_0001, 0, 9);

        // Reverse requested at cnt 4: old pattern finishes, 32 dead cycles, then pwm_b
        duty_reg = 32'd3;
        chk_run(1'b0, 3, 10, 32'h0003_0001, 0, 4);
        ctrl_reg = 32'd3;
        chk_run(1'b0, 3, 10, 32'h0003_0001, 5, 9);
        chk_dead(32);
        chk_run(1'b1, 3, 10, 32'h0003_0005, 0, 9);

        // Enable dropped at cnt 2: low and idle from next cycle
        chk_run(1'b1, 3, 10, 32'h0003_0005, 0, 2);
        ctrl_reg = 32'd2;
        chk_idle(3);

        // Re-enable restarts at cnt 0 in the registered direction
        ctrl_reg = 32'd3;
        chk_run(1'b1, 3, 10, 32'h0003_0005, 0, 9);

        // Back to forward, reset during dead time, resume forward after reset
        ctrl_reg = 32'd1;
        chk_dead(5);
        ARESETN = 1'b0;
        chk_idle(1);
        ARESETN = 1'b1;
        chk_run(1'b0, 3, 10, 32'h0003_0001, 0, 9);

        // Period 0 loaded at the wrap returns to IDLE
        period_reg = 32'd0;
        chk_idle(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
